spi_cntrl: RTL and testbench

- Synthesizable SPI controller (initiator) for the `spi_cntrl` lab; it drives `SPI_SCLK`, `SPI_MOSI` and `SPI_CS` and samples `SPI_MISO`.
- Transfers one 8-bit byte per `start`, MSB first, in SPI mode 0 (CPOL=0, CPHA=0).
- `hold_cs` chains bytes under a single CS assertion.
- Sits between user logic (byte/handshake side) and an external SPI subunit, which in simulation is the team's SPI subunit model.

---
 rtl/spi_cntrl_pkg.sv | 15 +
 rtl/spi_cntrl_if.sv | 28 ++
 rtl/spi_cntrl.sv | 152 +++++++++++++++
 tb/tb_spi_cntrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cntrl_pkg.sv
// Shared types and constants for the SPI mode-0 byte controller.
package spi_cntrl_pkg;

   localparam int unsigned SPI_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StSclkHi,
      StSclkLo,
      StHold,
      StCsOff
   } spi_state_t;

endpackage

// File: rtl/spi_cntrl_if.sv
// User-side byte handshake plus SPI pins of the controller, bundled as one interface.
interface spi_cntrl_if
   import spi_cntrl_pkg::*;
();

   logic                      start;
   logic [SPI_DATA_WIDTH-1:0] data_to_send;
   logic                      hold_cs;
   logic [SPI_DATA_WIDTH-1:0] data_received;
   logic                      busy;
   logic                      done;
   logic                      SPI_SCLK;
   logic                      SPI_MOSI;
   logic                      SPI_MISO;
   logic                      SPI_CS;

   // slave: the controller itself; master: user logic and the far-end subunit
   modport slave (
      input  start, data_to_send, hold_cs, SPI_MISO,
      output data_received, busy, done, SPI_SCLK, SPI_MOSI, SPI_CS
   );

   modport master (
      output start, data_to_send, hold_cs, SPI_MISO,
      input  data_received, busy, done, SPI_SCLK, SPI_MOSI, SPI_CS
   );

endinterface

// File: rtl/spi_cntrl.sv
// SPI initiator: one MSB-first byte per start in mode 0, with hold_cs chaining bytes under one CS.
module spi_cntrl
   import spi_cntrl_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY  = 100_000_000,
   parameter int unsigned SCLK_FREQUENCY = 500_000
) (
   input logic        clk,
   input logic        rst,
   spi_cntrl_if.slave bus_io
);

   localparam int unsigned HALF = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
   localparam int unsigned CW   = (HALF < 2) ? 1 : $clog2(HALF);
   localparam logic [CW-1:0] LAST_CNT = CW'(HALF - 1);
   localparam logic [3:0]    LAST_BIT = 4'(SPI_DATA_WIDTH);
   localparam int unsigned   W        = SPI_DATA_WIDTH;

   if (HALF < 2) begin : g_half_chk
      $fatal(1, "spi_cntrl: SCLK half-period must be at least 2 clk cycles");
   end

   spi_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [W-1:0]  tx_q, tx_d;
   logic [W-1:0]  rx_q, rx_d;
   logic [W-1:0]  rcv_q, rcv_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          cs_q, cs_d;
   logic          done_q, done_d;
   logic          half_end;

   assign half_end = (cnt_q == LAST_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rcv_q     <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b1;
         cs_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rcv_q     <= rcv_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_q      <= cs_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rcv_d     = rcv_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_d      = cs_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle, StHold: begin
            if (bus_io.start) begin
               tx_d      = bus_io.data_to_send;
               mosi_d    = bus_io.data_to_send[W-1];
               cs_d      = 1'b0;
               bit_cnt_d = '0;
               state_d   = StSetup;
            end else if (state_q == StHold && !bus_io.hold_cs) begin
               cs_d    = 1'b1;
               mosi_d  = 1'b1;
               state_d = StCsOff;
            end
         end
         StSetup: begin
            if (half_end) begin
               sclk_d  = 1'b1;
               rx_d    = {rx_q[W-2:0], bus_io.SPI_MISO};
               state_d = StSclkHi;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StSclkHi: begin
            if (half_end) begin
               sclk_d    = 1'b0;
               bit_cnt_d = bit_cnt_q + 4'd1;
               state_d   = StSclkLo;
               if (bit_cnt_d < LAST_BIT) begin
                  tx_d   = {tx_q[W-2:0], 1'b0};
                  mosi_d = tx_q[W-2];
               end else begin
                  // Byte ends on the last SCLK fall, so done lands 16 half-periods after CS fall.
                  done_d = 1'b1;
                  rcv_d  = rx_q;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StSclkLo: begin
            if (bit_cnt_q == LAST_BIT) begin
               bit_cnt_d = '0;
               if (bus_io.hold_cs) begin
                  state_d = StHold;
               end else begin
                  cs_d    = 1'b1;
                  mosi_d  = 1'b1;
                  state_d = StCsOff;
               end
            end else if (half_end) begin
               sclk_d  = 1'b1;
               rx_d    = {rx_q[W-2:0], bus_io.SPI_MISO};
               state_d = StSclkHi;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StCsOff: begin
            if (half_end) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus_io.busy          = (state_q != StIdle);
      bus_io.done          = done_q;
      bus_io.data_received = rcv_q;
      bus_io.SPI_SCLK      = sclk_q;
      bus_io.SPI_MOSI      = mosi_q;
      bus_io.SPI_CS        = cs_q;
   end

endmodule

// File: tb/tb_spi_cntrl.sv
// Bench for spi_cntrl: HALF=5 instance against a mode-0 subunit model, plus a default-parameter instance.
module tb_spi_cntrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_cntrl_if sif ();
   spi_cntrl_if sif_def ();

   spi_cntrl #(
      .CLK_FREQUENCY (5_000_000),
      .SCLK_FREQUENCY(500_000)
   ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .bus_io(sif)
   );

   spi_cntrl u_dut_def (
      .clk   (clk),
      .rst   (rst),
      .bus_io(sif_def)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Subunit model: MISO updated after SCLK falls, MOSI captured on SCLK rises.
   logic [7:0] sub_q[$];
   logic [7:0] sub_shift   = 8'hFF;
   logic [7:0] sub_rx      = 8'h00;
   logic [7:0] last_sub_rx = 8'h00;
   int         sub_bits    = 0;
   int         sub_rx_cnt  = 0;
   int         rise_cnt    = 0;

   assign sif.SPI_MISO     = sub_shift[7];
   assign sif_def.SPI_MISO = 1'b0;

   task automatic sub_load();
      if (sub_q.size() > 0) sub_shift = sub_q.pop_front();
      else sub_shift = 8'hFF;
   endtask

   always @(negedge sif.SPI_CS) begin
      sub_load();
      sub_bits = 0;
   end

   always @(posedge sif.SPI_CS) sub_bits = 0;

   always @(posedge sif.SPI_SCLK) begin
      if (!sif.SPI_CS) begin
         sub_rx = {sub_rx[6:0], sif.SPI_MOSI};
         sub_bits++;
         rise_cnt++;
         if (sub_bits == 8) begin
            last_sub_rx = sub_rx;
            sub_rx_cnt++;
            sub_bits = 0;
         end
      end
   end

   always @(negedge sif.SPI_SCLK) begin
      if (!sif.SPI_CS) begin
         if (sub_bits == 0) sub_load();
         else sub_shift = {sub_shift[6:0], 1'b1};
      end
   end

   int   cyc = 0;
   int   done_cnt = 0, done_cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, cs_rise_cnt = 0;
   int   def_done_cnt = 0, def_rise_n = 0, def_r0 = 0, def_r1 = 0;
   logic cs_prev = 1'b1, def_sclk_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sif.done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (cs_prev === 1'b1 && sif.SPI_CS === 1'b0) cs_fall_cyc = cyc;
      if (cs_prev === 1'b0 && sif.SPI_CS === 1'b1) begin
         cs_rise_cyc = cyc;
         cs_rise_cnt++;
      end
      cs_prev = sif.SPI_CS;
      if (sif_def.done === 1'b1) def_done_cnt++;
      if (def_sclk_prev === 1'b0 && sif_def.SPI_SCLK === 1'b1) begin
         if (def_rise_n == 0) def_r0 = cyc;
         else if (def_rise_n == 1) def_r1 = cyc;
         def_rise_n++;
      end
      def_sclk_prev = sif_def.SPI_SCLK;
   end

   task automatic start_byte(input logic [7:0] d, input logic hold);
      @(negedge clk);
      sif.data_to_send = d;
      sif.hold_cs      = hold;
      sif.start        = 1'b1;
      @(negedge clk);
      sif.start        = 1'b0;
      sif.data_to_send = ~d;
   endtask

   task automatic wait_idle(input int max, input string name);
      int n = 0;
      while (sif.busy !== 1'b0 && n < max) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_idle_timeout"}, 32'(n < max), 32'd1);
   endtask

   task automatic wait_done(input int target, input int max, input string name);
      int n = 0;
      while (done_cnt < target && n < max) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done_timeout"}, 32'(done_cnt >= target), 32'd1);
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [7:0] miso;
      logic [7:0] exp_sub;
      logic [7:0] exp_rcv;
      int         exp_lat;
      int         exp_rises;
   } vec_t;

   localparam int NV = 5;
   vec_t vecs[NV];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, r0, s0, c0, n;

      vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 80, 8};
      vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 80, 8};
      vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 80, 8};
      vecs[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E, 80, 8};
      vecs[4] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3, 80, 8};

      sif.start = 1'b0;  sif.data_to_send = 8'h00;  sif.hold_cs = 1'b0;
      sif_def.start = 1'b0;  sif_def.data_to_send = 8'h00;  sif_def.hold_cs = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_cs", sif.SPI_CS, 1);
      chk("rst_sclk", sif.SPI_SCLK, 0);
      chk("rst_mosi", sif.SPI_MOSI, 1);
      chk("rst_busy", sif.busy, 0);
      chk("rst_done", sif.done, 0);
      chk("rst_rcv", sif.data_received, 8'h00);
      chk("no_x", 32'($isunknown({sif.SPI_CS, sif.SPI_SCLK, sif.SPI_MOSI, sif.busy, sif.done,
                                  sif.data_received})), 0);
      chk("no_x_def", 32'($isunknown({sif_def.SPI_CS, sif_def.SPI_SCLK, sif_def.SPI_MOSI,
                                      sif_def.busy, sif_def.done, sif_def.data_received})), 0);

      // Single bytes, hold_cs=0
      for (int i = 0; i < NV; i++) begin
         sub_q.push_back(vecs[i].miso);
         d0 = done_cnt;  r0 = rise_cnt;  s0 = sub_rx_cnt;
         start_byte(vecs[i].tx, 1'b0);
         chk("busy_after_start", sif.busy, 1);
         wait_idle(200, "vec");
         chk("vec_sub_rx", last_sub_rx, vecs[i].exp_sub);
         chk("vec_sub_cnt", sub_rx_cnt - s0, 1);
         chk("vec_rcv", sif.data_received, vecs[i].exp_rcv);
         chk("vec_lat", done_cyc - cs_fall_cyc, vecs[i].exp_lat);
         chk("vec_cs_after_done", cs_rise_cyc - done_cyc, 1);
         chk("vec_rises", rise_cnt - r0, vecs[i].exp_rises);
         chk("vec_done_cnt", done_cnt - d0, 1);
         chk("vec_mosi_idle", sif.SPI_MOSI, 1);
      end

      // Start while busy is ignored
      sub_q.push_back(8'h96);
      d0 = done_cnt;  r0 = rise_cnt;
      start_byte(8'hC3, 1'b0);
      repeat (30) @(negedge clk);
      sif.data_to_send = 8'h00;
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      wait_idle(200, "midstart");
      repeat (20) @(negedge clk);
      chk("midstart_busy", sif.busy, 0);
      chk("midstart_done_cnt", done_cnt - d0, 1);
      chk("midstart_rises", rise_cnt - r0, 8);
      chk("midstart_sub_rx", last_sub_rx, 8'hC3);
      chk("midstart_rcv", sif.data_received, 8'h96);

      // Chained bytes under one CS, then HOLD exit without start
      sub_q.push_back(8'h11);
      sub_q.push_back(8'h22);
      d0 = done_cnt;  r0 = rise_cnt;  s0 = sub_rx_cnt;  c0 = cs_rise_cnt;
      start_byte(8'h01, 1'b1);
      wait_done(d0 + 1, 200, "chain1");
      repeat (3) @(negedge clk);
      chk("hold_busy", sif.busy, 1);
      chk("hold_cs_low", sif.SPI_CS, 0);
      chk("hold_sclk_low", sif.SPI_SCLK, 0);
      chk("chain1_rcv", sif.data_received, 8'h11);
      chk("chain1_sub_rx", last_sub_rx, 8'h01);
      start_byte(8'hFF, 1'b1);
      wait_done(d0 + 2, 200, "chain2");
      repeat (3) @(negedge clk);
      chk("chain_cs_rises", cs_rise_cnt - c0, 0);
      chk("chain_sclk_rises", rise_cnt - r0, 16);
      chk("chain_done_cnt", done_cnt - d0, 2);
      chk("chain_sub_cnt", sub_rx_cnt - s0, 2);
      chk("chain2_sub_rx", last_sub_rx, 8'hFF);
      chk("chain2_rcv", sif.data_received, 8'h22);
      sif.hold_cs = 1'b0;
      @(negedge clk);
      chk("holdexit_cs", sif.SPI_CS, 1);
      chk("holdexit_mosi", sif.SPI_MOSI, 1);
      n = 0;
      while (sif.busy === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("holdexit_busy_cycles", n, 5);
      chk("holdexit_done_cnt", done_cnt - d0, 2);

      // Async reset at the 4th SCLK rise aborts the byte
      sub_q.push_back(8'h0F);
      d0 = done_cnt;  r0 = rise_cnt;
      start_byte(8'h96, 1'b0);
      n = 0;
      while (rise_cnt - r0 < 4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_rise_timeout", 32'(n < 200), 1);
      rst = 1'b1;
      #1;
      chk("abort_cs", sif.SPI_CS, 1);
      chk("abort_sclk", sif.SPI_SCLK, 0);
      chk("abort_busy", sif.busy, 0);
      chk("abort_done", sif.done, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_rcv", sif.data_received, 8'h00);
      chk("abort_done_cnt", done_cnt - d0, 0);
      sub_q.delete();
      sub_q.push_back(8'hA5);
      s0 = sub_rx_cnt;
      start_byte(8'h5A, 1'b0);
      wait_idle(200, "after_abort");
      chk("after_abort_sub_rx", last_sub_rx, 8'h5A);
      chk("after_abort_sub_cnt", sub_rx_cnt - s0, 1);
      chk("after_abort_rcv", sif.data_received, 8'hA5);
      chk("after_abort_done_cnt", done_cnt - d0, 1);

      // Default parameters: HALF=100
      @(negedge clk);
      sif_def.data_to_send = 8'h55;
      sif_def.start = 1'b1;
      @(negedge clk);
      sif_def.start = 1'b0;
      n = 0;
      while (sif_def.busy !== 1'b0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk("def_idle_timeout", 32'(n < 4000), 1);
      chk("def_sclk_period", def_r1 - def_r0, 200);
      chk("def_sclk_rises", def_rise_n, 8);
      chk("def_done_cnt", def_done_cnt, 1);
      chk("def_rcv", sif_def.data_received, 8'h00);
      chk("def_cs_idle", sif_def.SPI_CS, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
